// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin IDLE/ACCESS/DONE sequencer sharing the single-port data memory
// between the CPU and DMA ports; sub-word stores are merged against the combinational read word.
module dm_arbiter #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [3:0]  c_be,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [31:0] c_pc,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic        rr;       // 0: CPU has priority, 1: DMA
  logic        own;      // owner of the access in flight, same encoding
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic        err_q;

  logic        pick_d;
  logic        addr_err;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign pick_d    = d_req & (~c_req | rr);
  // mem_addr holds the latched address from IDLE until the next grant
  assign addr_err  = (|mem_addr[31:AW+2]) || (32'(mem_addr[AW+1:2]) >= 32'(DEPTH));
  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign merged    = (mem_rd & ~lane_mask) | (wdata_q & lane_mask);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      own      <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      err_q    <= 1'b0;
      c_ack    <= 1'b0;
      d_ack    <= 1'b0;
      c_err    <= 1'b0;
      d_err    <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_pc   <= '0;
    end else begin
      c_ack  <= 1'b0;
      d_ack  <= 1'b0;
      c_err  <= 1'b0;
      d_err  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || d_req) begin
            own <= pick_d;
            if (pick_d) begin
              we_q     <= d_we;
              be_q     <= d_be;
              mem_addr <= d_addr;
              wdata_q  <= d_wdata;
              pc_q     <= '0;
            end else begin
              we_q     <= c_we;
              be_q     <= c_be;
              mem_addr <= c_addr;
              wdata_q  <= c_wdata;
              pc_q     <= c_pc;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          err_q <= addr_err;
          if (we_q) begin
            if (!addr_err && be_q != 4'd0) begin
              mem_we <= 1'b1;
              mem_wd <= merged;
              mem_pc <= pc_q;
            end
          end else if (own) begin
            d_rdata <= addr_err ? 32'd0 : mem_rd;
          end else begin
            c_rdata <= addr_err ? 32'd0 : mem_rd;
          end
          state <= DONE;
        end
        DONE: begin
          if (own) begin
            d_ack <= 1'b1;
            d_err <= err_q;
          end else begin
            c_ack <= 1'b1;
            c_err <= err_q;
          end
          rr    <= ~own;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized single/contended traffic
// checked against a word-array model with its own round-robin bookkeeping.
module tb_dm_arbiter;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        c_req, c_we, d_req, d_we;
  logic [3:0]  c_be, d_be;
  logic [31:0] c_addr, c_wdata, c_pc, d_addr, d_wdata;
  logic        c_ack, c_err, d_ack, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_pc, mem_rd;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [31:0] last_pc = '0;
  bit          rr_model = 1'b0;

  logic [31:0] mem       [0:4095];
  bit          mem_valid [0:4095];
  logic [31:0] model     [0:3071];

  dm_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input logic [11:0] w);
    return {w, 4'hA, w, 4'h5} ^ 32'h1357_9BDF;
  endfunction

  // Memory array: combinational read, write on the edge while mem_we is high
  assign mem_rd = (mem_addr[31:2] < 30'd3072) ?
                  (mem_valid[mem_addr[13:2]] ? mem[mem_addr[13:2]] : init_word(mem_addr[13:2])) : 32'h0;

  always @(posedge CLK) begin
    if (mem_we === 1'b1) begin
      we_cnt++;
      last_pc = mem_pc;
      if (mem_addr[31:2] < 30'd3072) begin
        mem[mem_addr[13:2]]       <= mem_wd;
        mem_valid[mem_addr[13:2]] <= 1'b1;
      end
    end
  end

  // Reference: word-granular store with lane overwrite; out-of-range reads return 0
  task automatic model_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int w;
    w  = int'(addr >> 2);
    er = (w >= 3072);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = model[w];
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1;
    c_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    rr_model = 1'b0;
  endtask

  task automatic run_txn(input bit port, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                         output int lat, output logic [31:0] rd, output logic er, output bit other);
    @(negedge CLK);
    if (port) begin
      d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      c_we = we; c_be = be; c_addr = addr; c_wdata = wdata; c_pc = pc; c_req = 1'b1;
    end
    lat = 0;
    other = 1'b0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
      if ((port ? c_ack : d_ack) === 1'b1) other = 1'b1;
    end while ((port ? d_ack : c_ack) !== 1'b1 && lat < 20);
    rd = port ? d_rdata : c_rdata;
    er = port ? d_err : c_err;
    @(negedge CLK);
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic run_pair(input logic cwe, input logic [3:0] cbe, input logic [31:0] caddr,
                          input logic [31:0] cwd, input logic [31:0] cpc,
                          input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                          input logic [31:0] dwd,
                          output int c_cyc, output int d_cyc, output logic [31:0] crd,
                          output logic [31:0] drd, output logic ce, output logic de);
    int cyc;
    @(negedge CLK);
    c_we = cwe; c_be = cbe; c_addr = caddr; c_wdata = cwd; c_pc = cpc;
    d_we = dwe; d_be = dbe; d_addr = daddr; d_wdata = dwd;
    c_req = 1'b1;
    d_req = 1'b1;
    cyc = 0; c_cyc = 0; d_cyc = 0;
    crd = '0; drd = '0; ce = 1'b0; de = 1'b0;
    while ((c_cyc == 0 || d_cyc == 0) && cyc < 20) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (c_ack === 1'b1 && c_cyc == 0) begin c_cyc = cyc; crd = c_rdata; ce = c_err; end
      if (d_ack === 1'b1 && d_cyc == 0) begin d_cyc = cyc; drd = d_rdata; de = d_err; end
      @(negedge CLK);
      if (c_cyc != 0) c_req = 1'b0;
      if (d_cyc != 0) d_req = 1'b0;
    end
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if ({c_ack, d_ack, c_err, d_err} !== 4'b0) begin n_err++; $display("FAIL reset_ack_err: got %b want 0000", {c_ack, d_ack, c_err, d_err}); end
    n_cmp++; if (c_rdata !== 32'h0) begin n_err++; $display("FAIL reset_c_rdata: got %h want 0", c_rdata); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if ({mem_addr, mem_wd, mem_pc} !== 96'h0) begin n_err++; $display("FAIL reset_mem_bus: got %h/%h/%h want 0", mem_addr, mem_wd, mem_pc); end
    @(negedge CLK);
    Reset = 1'b0;
    rr_model = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, w0; logic [31:0] rd, exp; logic er, xe; bit oth;
    w0 = we_cnt;
    run_txn(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0000_0400, lat, rd, er, oth);
    model_txn(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, exp, xe);
    rr_model = 1'b1;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (we_cnt - w0 !== 1) begin n_err++; $display("FAIL wr_we_pulses: got %0d want 1", we_cnt - w0); end
    n_cmp++; if (last_pc !== 32'h0000_0400) begin n_err++; $display("FAIL wr_mem_pc: got %h want 00000400", last_pc); end
    run_txn(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, lat, rd, er, oth);
    rr_model = 1'b1;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", er); end
  endtask

  task automatic test_dma_byte();
    int lat; logic [31:0] rd, exp; logic er, xe; bit oth;
    run_txn(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_AA00, 32'h0, lat, rd, er, oth);
    model_txn(1'b1, 4'b0010, 32'h10, 32'h0000_AA00, exp, xe);
    rr_model = 1'b0;
    n_cmp++; if (oth !== 1'b0) begin n_err++; $display("FAIL dma_c_ack_quiet: got %b want 0", oth); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL dma_latency: got %0d want 3", lat); end
    n_cmp++; if (last_pc !== 32'h0) begin n_err++; $display("FAIL dma_mem_pc: got %h want 0", last_pc); end
    run_txn(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, lat, rd, er, oth);
    rr_model = 1'b1;
    n_cmp++; if (rd !== 32'hDEAD_AAEF) begin n_err++; $display("FAIL dma_merge: got %h want deadaaef", rd); end
  endtask

  task automatic test_arbitration();
    logic [31:0] exp_c, exp_d; logic e; int cyc;
    do_reset();
    model_txn(1'b0, 4'hF, 32'h10, 32'h0, exp_c, e);
    model_txn(1'b0, 4'hF, 32'h24, 32'h0, exp_d, e);
    @(negedge CLK);
    c_we = 1'b0; c_be = 4'hF; c_addr = 32'h10;
    d_we = 1'b0; d_be = 4'h0; d_addr = 32'h24;
    c_req = 1'b1;
    d_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc = 0;
      do begin
        @(posedge CLK);
        #1;
        cyc++;
      end while (c_ack !== 1'b1 && d_ack !== 1'b1 && cyc < 10);
      n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL arb_spacing_%0d: got %0d want 3", k, cyc); end
      n_cmp++; if ({c_ack, d_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL arb_order_%0d: got c/d ack %b%b want %s", k, c_ack, d_ack, (k % 2 == 0) ? "CPU" : "DMA");
      end
      n_cmp++; if (((k % 2 == 0) ? c_rdata : d_rdata) !== ((k % 2 == 0) ? exp_c : exp_d)) begin
        n_err++; $display("FAIL arb_rdata_%0d: got %h want %h", k, (k % 2 == 0) ? c_rdata : d_rdata, (k % 2 == 0) ? exp_c : exp_d);
      end
    end
    @(negedge CLK);
    c_req = 1'b0;
    d_req = 1'b0;
    rr_model = 1'b0;
  endtask

  task automatic test_bounds();
    int lat, w0; logic [31:0] rd, exp; logic er, xe; bit oth;
    w0 = we_cnt;
    run_txn(1'b0, 1'b0, 4'hF, 32'h3000, 32'h0, 32'h0, lat, rd, er, oth);
    n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL oob_rd_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL oob_rd_data: got %h want 0", rd); end
    run_txn(1'b1, 1'b1, 4'hF, 32'h3000, 32'hFFFF_FFFF, 32'h0, lat, rd, er, oth);
    n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL oob_wr_err: got %b want 1", er); end
    n_cmp++; if (we_cnt - w0 !== 0) begin n_err++; $display("FAIL oob_no_write: got %0d pulses want 0", we_cnt - w0); end
    run_txn(1'b0, 1'b1, 4'b1001, 32'h2FFE, 32'hA5C3_3C5A, 32'h8, lat, rd, er, oth);
    model_txn(1'b1, 4'b1001, 32'h2FFE, 32'hA5C3_3C5A, exp, xe);
    n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL last_word_err: got %b want 0", er); end
    run_txn(1'b1, 1'b0, 4'h0, 32'h2FFC, 32'h0, 32'h0, lat, rd, er, oth);
    model_txn(1'b0, 4'h0, 32'h2FFC, 32'h0, exp, xe);
    rr_model = 1'b0;
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL last_word_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_be_zero();
    int lat, w0; logic [31:0] rd, exp; logic er, xe; bit oth;
    w0 = we_cnt;
    run_txn(1'b0, 1'b1, 4'h0, 32'h10, 32'h1234_5678, 32'h44, lat, rd, er, oth);
    model_txn(1'b1, 4'h0, 32'h10, 32'h1234_5678, exp, xe);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL be0_latency: got %0d want 3", lat); end
    n_cmp++; if (we_cnt - w0 !== 0) begin n_err++; $display("FAIL be0_no_write: got %0d pulses want 0", we_cnt - w0); end
    run_txn(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, lat, rd, er, oth);
    model_txn(1'b0, 4'hF, 32'h10, 32'h0, exp, xe);
    rr_model = 1'b1;
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL be0_unchanged: got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_midflight();
    int lat, w0, acks, c_cyc, d_cyc; logic [31:0] rd, crd, drd, exp; logic er, ce, de, xe; bit oth;
    run_txn(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h0, lat, rd, er, oth);
    w0 = we_cnt;
    acks = 0;
    @(negedge CLK);
    c_we = 1'b1; c_be = 4'hF; c_addr = 32'h40; c_wdata = 32'h1234_5678; c_pc = 32'h100;
    c_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    c_req = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    rr_model = 1'b0;
    repeat (5) begin
      @(posedge CLK);
      #1;
      if (c_ack === 1'b1 || d_ack === 1'b1) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL midrst_no_ack: got %0d acks want 0", acks); end
    n_cmp++; if (we_cnt - w0 !== 0) begin n_err++; $display("FAIL midrst_no_write: got %0d pulses want 0", we_cnt - w0); end
    run_pair(1'b0, 4'hF, 32'h40, 32'h0, 32'h0, 1'b0, 4'hF, 32'h44, 32'h0, c_cyc, d_cyc, crd, drd, ce, de);
    model_txn(1'b0, 4'hF, 32'h40, 32'h0, exp, xe);
    rr_model = 1'b0;
    n_cmp++; if (c_cyc !== 3 || d_cyc !== 6) begin n_err++; $display("FAIL midrst_rr_cpu: got c@%0d d@%0d want c@3 d@6", c_cyc, d_cyc); end
    n_cmp++; if (crd !== exp) begin n_err++; $display("FAIL midrst_mem_kept: got %h want %h", crd, exp); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [29:0] w;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)     w = 30'($urandom_range(3072, 3100));
    else if (r < 3) w = 30'($urandom_range(3064, 3071));
    else            w = 30'($urandom_range(0, 15));
    return {w, 2'($urandom_range(0, 3))};
  endfunction

  task automatic test_random();
    int lat, c_cyc, d_cyc, mode; bit port, oth, first;
    logic cwe, dwe, er, ce, de, xe, xce, xde;
    logic [3:0] cbe, dbe;
    logic [31:0] ca, da, cwd, dwd, cpc, rd, crd, drd, exp, xc, xd;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      cwe = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
      cbe = 4'($urandom_range(0, 15)); dbe = 4'($urandom_range(0, 15));
      ca = rand_addr(); da = rand_addr();
      cwd = $urandom(); dwd = $urandom(); cpc = $urandom();
      if (mode < 2) begin
        port = (mode == 1);
        run_txn(port, port ? dwe : cwe, port ? dbe : cbe, port ? da : ca, port ? dwd : cwd, cpc,
                lat, rd, er, oth);
        model_txn(port ? dwe : cwe, port ? dbe : cbe, port ? da : ca, port ? dwd : cwd, exp, xe);
        rr_model = ~port;
        n_cmp++; if (lat !== 3 || oth !== 1'b0) begin n_err++; $display("FAIL rnd_lat_%0d: got %0d other=%b want 3 other=0", i, lat, oth); end
        n_cmp++; if (er !== xe) begin n_err++; $display("FAIL rnd_err_%0d: got %b want %b", i, er, xe); end
        if (!(port ? dwe : cwe)) begin
          n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rnd_rdata_%0d: got %h want %h", i, rd, exp); end
        end
      end else begin
        first = rr_model;
        run_pair(cwe, cbe, ca, cwd, cpc, dwe, dbe, da, dwd, c_cyc, d_cyc, crd, drd, ce, de);
        if (!first) begin
          model_txn(cwe, cbe, ca, cwd, xc, xce);
          model_txn(dwe, dbe, da, dwd, xd, xde);
        end else begin
          model_txn(dwe, dbe, da, dwd, xd, xde);
          model_txn(cwe, cbe, ca, cwd, xc, xce);
        end
        rr_model = first;
        n_cmp++; if (c_cyc !== (first ? 6 : 3) || d_cyc !== (first ? 3 : 6)) begin
          n_err++; $display("FAIL rnd_pair_order_%0d: got c@%0d d@%0d want c@%0d d@%0d", i, c_cyc, d_cyc, first ? 6 : 3, first ? 3 : 6);
        end
        n_cmp++; if ({ce, de} !== {xce, xde}) begin n_err++; $display("FAIL rnd_pair_err_%0d: got %b%b want %b%b", i, ce, de, xce, xde); end
        if (!cwe) begin
          n_cmp++; if (crd !== xc) begin n_err++; $display("FAIL rnd_pair_c_rdata_%0d: got %h want %h", i, crd, xc); end
        end
        if (!dwe) begin
          n_cmp++; if (drd !== xd) begin n_err++; $display("FAIL rnd_pair_d_rdata_%0d: got %h want %h", i, drd, xd); end
        end
      end
    end
  endtask

  task automatic test_final_memory();
    int bad;
    logic [31:0] act;
    repeat (2) @(posedge CLK);
    bad = 0;
    for (int w = 0; w < 3072; w++) begin
      act = mem_valid[w] ? mem[w] : init_word(12'(w));
      if (act !== model[w]) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL final_memory: got %0d differing words want 0", bad); end
  endtask

  initial begin
    Reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_be = 4'h0; c_addr = '0; c_wdata = '0; c_pc = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    for (int w = 0; w < 3072; w++) model[w] = init_word(12'(w));
    test_reset();
    test_write_read();
    test_dma_byte();
    test_arbitration();
    test_bounds();
    test_be_zero();
    test_reset_midflight();
    test_random();
    test_final_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
